// File: rtl/hd_lat_pkg.sv
// rtl/hd_lat_pkg.sv - shared state type, sim-env defaults and latency legality check for hd_latency_pipe
package hd_lat_pkg;

  localparam int HD_W       = 8;
  localparam int HD_MAX_LAT = 16;
  localparam int HD_DEF_LAT = 4;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } hd_lat_state_e;

  // A latency is usable only if it selects at least one stage and fits in the pipe.
  function automatic logic lat_legal(input logic [31:0] l, input logic [31:0] max_lat);
    return (l != 32'd0) && (l <= max_lat);
  endfunction

endpackage

// File: rtl/hd_lat_ctrl.sv
// rtl/hd_lat_ctrl.sv - fill FSM, latency register, error flag and flush/change detection for hd_latency_pipe
module hd_lat_ctrl
  import hd_lat_pkg::*;
#(
  parameter int MAX_LAT = HD_MAX_LAT,
  parameter int DEF_LAT = HD_DEF_LAT,
  parameter int LAT_W   = $clog2(MAX_LAT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             flush_i,
  input  logic [LAT_W-1:0] lat_i,
  output logic [LAT_W-1:0] lat_q_o,
  output logic             clr_vld_o,
  output logic             busy_o,
  output logic             lat_err_o
);

  localparam logic [LAT_W-1:0] CNT_MAX = LAT_W'(MAX_LAT);

  hd_lat_state_e    state_q, state_d;
  logic [LAT_W-1:0] cnt_q, cnt_d;
  logic [LAT_W-1:0] lat_q, lat_d;
  logic             lat_err_q;
  logic             lat_ok;
  logic             lat_chg;

  // Illegal requests are flagged but never adopted; a legal new value restarts the pipe.
  assign lat_ok    = lat_legal(32'(lat_i), 32'(MAX_LAT));
  assign lat_chg   = lat_ok && (lat_i != lat_q);
  assign clr_vld_o = flush_i || lat_chg;

  assign lat_q_o   = lat_q;
  assign busy_o    = (state_q == FILL);
  assign lat_err_o = lat_err_q;

  // Next-state: clear wins, otherwise count enabled edges while filling.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lat_d   = lat_q;
    if (lat_chg) lat_d = lat_i;
    if (clr_vld_o) begin
      state_d = FILL;
      cnt_d   = '0;
    end else if (en_i && (state_q == FILL)) begin
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
      if (cnt_d >= lat_q - 1'b1) state_d = RUN;
    end
  end

  // State, counter, latency and error registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= FILL;
      cnt_q     <= '0;
      lat_q     <= LAT_W'(DEF_LAT);
      lat_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      lat_q     <= lat_d;
      lat_err_q <= !lat_ok;
    end
  end

endmodule

// File: rtl/hd_latency_pipe.sv
// rtl/hd_latency_pipe.sv - programmable latency matcher; HD_LAT_OCC_EN adds the occ occupancy port
module hd_latency_pipe
  import hd_lat_pkg::*;
#(
  parameter int W       = HD_W,
  parameter int MAX_LAT = HD_MAX_LAT,
  parameter int DEF_LAT = HD_DEF_LAT,
  parameter int LAT_W   = $clog2(MAX_LAT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             flush,
  input  logic [LAT_W-1:0] lat,
  input  logic [W-1:0]     din,
  input  logic             dvld,
  output logic [W-1:0]     qout,
  output logic             qvld,
  output logic             busy,
  output logic             lat_err
`ifdef HD_LAT_OCC_EN
  ,
  output logic [LAT_W-1:0] occ
`endif
);

  logic [W-1:0]       dat_q [MAX_LAT];
  logic [MAX_LAT-1:0] vld_q;
  logic [LAT_W-1:0]   lat_q;
  logic [LAT_W-1:0]   lat_m1;
  logic               clr_vld;
  logic [W-1:0]       tap_dat;
  logic               tap_vld;

  hd_lat_ctrl #(
    .MAX_LAT (MAX_LAT),
    .DEF_LAT (DEF_LAT),
    .LAT_W   (LAT_W)
  ) u_ctrl (
    .clk       (clk),
    .rst       (rst),
    .en_i      (en),
    .flush_i   (flush),
    .lat_i     (lat),
    .lat_q_o   (lat_q),
    .clr_vld_o (clr_vld),
    .busy_o    (busy),
    .lat_err_o (lat_err)
  );

  assign lat_m1 = lat_q - 1'b1;

  // Shift register; a clear drops every valid bit and also discards this edge's input.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < MAX_LAT; i++) dat_q[i] <= '0;
      vld_q <= '0;
    end else if (clr_vld) begin
      vld_q <= '0;
    end else if (en) begin
      dat_q[0] <= din;
      vld_q[0] <= dvld;
      for (int i = 1; i < MAX_LAT; i++) begin
        dat_q[i] <= dat_q[i-1];
        vld_q[i] <= vld_q[i-1];
      end
    end
  end

  // Output tap sits lat_q-1 stages behind the write point.
  always_comb begin
    tap_dat = '0;
    tap_vld = 1'b0;
    for (int i = 0; i < MAX_LAT; i++) begin
      if (LAT_W'(i) == lat_m1) begin
        tap_dat = dat_q[i];
        tap_vld = vld_q[i];
      end
    end
  end

  assign qout = tap_dat;
  assign qvld = tap_vld;

`ifdef HD_LAT_OCC_EN
  logic [LAT_W-1:0] occ_q;

  // Valid samples inside the effective stages: in at stage 0, out past the tap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ_q <= '0;
    end else if (clr_vld) begin
      occ_q <= '0;
    end else if (en) begin
      occ_q <= occ_q + LAT_W'(dvld) - LAT_W'(tap_vld);
    end
  end

  assign occ = occ_q;
`endif

endmodule

// File: tb/tb_hd_latency_pipe.sv
// tb/tb_hd_latency_pipe.sv - directed self-checking bench for hd_latency_pipe
module tb_hd_latency_pipe;

  localparam int W     = 8;
  localparam int LAT_W = 5;

  logic             clk;
  logic             rst;
  logic             en;
  logic             flush;
  logic [LAT_W-1:0] lat;
  logic [W-1:0]     din;
  logic             dvld;
  logic [W-1:0]     qout;
  logic             qvld;
  logic             busy;
  logic             lat_err;
`ifdef HD_LAT_OCC_EN
  logic [LAT_W-1:0] occ;
  logic [LAT_W-1:0] exp_lat;
`endif

  int        n_cmp;
  int        n_bad;
  logic [7:0] d;

  hd_latency_pipe #(
    .W       (8),
    .MAX_LAT (16),
    .DEF_LAT (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .flush   (flush),
    .lat     (lat),
    .din     (din),
    .dvld    (dvld),
    .qout    (qout),
    .qvld    (qvld),
    .busy    (busy),
    .lat_err (lat_err)
`ifdef HD_LAT_OCC_EN
    ,
    .occ     (occ)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef HD_LAT_OCC_EN
  // Occupancy may never exceed the effective latency.
  always @(negedge clk) begin
    if (rst) begin
      n_cmp++;
      if (occ > exp_lat) begin
        n_bad++;
        $display("FAIL occ_bound got %0d limit %0d", occ, exp_lat);
      end
    end
  end
`endif

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b1; flush = 1'b0; lat = 5'd4; din = 8'h00; dvld = 1'b0;
    #2;
    n_cmp += 4;
    if (qout !== 8'h00)  begin n_bad++; $display("FAIL rst_qout got %h want 00", qout); end
    if (qvld !== 1'b0)   begin n_bad++; $display("FAIL rst_qvld got %b want 0", qvld); end
    if (busy !== 1'b1)   begin n_bad++; $display("FAIL rst_busy got %b want 1", busy); end
    if (lat_err !== 1'b0) begin n_bad++; $display("FAIL rst_laterr got %b want 0", lat_err); end
`ifdef HD_LAT_OCC_EN
    n_cmp++;
    if (occ !== 5'd0) begin n_bad++; $display("FAIL rst_occ got %0d want 0", occ); end
`endif
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_run();
    d = 8'h01;
    for (int k = 1; k <= 8; k++) begin
      din = d; dvld = 1'b1;
      tick();
      n_cmp += 2;
      if (busy !== (k < 3)) begin n_bad++; $display("FAIL run_busy k=%0d got %b want %b", k, busy, (k < 3)); end
      if (qvld !== (k >= 4)) begin n_bad++; $display("FAIL run_qvld k=%0d got %b want %b", k, qvld, (k >= 4)); end
      if (k >= 4) begin
        n_cmp++;
        if (qout !== 8'(d - 8'd3)) begin n_bad++; $display("FAIL run_qout k=%0d got %h want %h", k, qout, 8'(d - 8'd3)); end
      end
`ifdef HD_LAT_OCC_EN
      n_cmp++;
      if (occ !== LAT_W'((k < 4) ? k : 4)) begin n_bad++; $display("FAIL run_occ k=%0d got %0d want %0d", k, occ, (k < 4) ? k : 4); end
`endif
      d++;
    end
  endtask

  task automatic test_stall();
    logic [7:0] held;
    held = 8'(d - 8'd4);
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      din = 8'hEE; dvld = 1'b1;
      tick();
      n_cmp += 2;
      if (qout !== held) begin n_bad++; $display("FAIL stall_qout k=%0d got %h want %h", k, qout, held); end
      if (qvld !== 1'b1) begin n_bad++; $display("FAIL stall_qvld k=%0d got %b want 1", k, qvld); end
    end
    en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      din = d; dvld = 1'b1;
      tick();
      n_cmp += 2;
      if (qout !== 8'(d - 8'd3)) begin n_bad++; $display("FAIL resume_qout k=%0d got %h want %h", k, qout, 8'(d - 8'd3)); end
      if (qvld !== 1'b1) begin n_bad++; $display("FAIL resume_qvld k=%0d got %b want 1", k, qvld); end
      d++;
    end
  endtask

  task automatic test_flush();
    logic [7:0] first;
    flush = 1'b1; din = 8'hAA; dvld = 1'b1;
    tick();
    flush = 1'b0;
    n_cmp += 2;
    if (qvld !== 1'b0) begin n_bad++; $display("FAIL flush_qvld got %b want 0", qvld); end
    if (busy !== 1'b1) begin n_bad++; $display("FAIL flush_busy got %b want 1", busy); end
    first = d;
    for (int k = 1; k <= 6; k++) begin
      din = d; dvld = 1'b1;
      tick();
      n_cmp += 2;
      if (qvld !== (k >= 4)) begin n_bad++; $display("FAIL postflush_qvld k=%0d got %b want %b", k, qvld, (k >= 4)); end
      if (busy !== (k < 3)) begin n_bad++; $display("FAIL postflush_busy k=%0d got %b want %b", k, busy, (k < 3)); end
      if (k == 4) begin
        n_cmp++;
        if (qout !== first) begin n_bad++; $display("FAIL postflush_first got %h want %h", qout, first); end
      end
      d++;
    end
  endtask

  task automatic test_lat_change();
    lat = 5'd1; din = 8'h55; dvld = 1'b1;
`ifdef HD_LAT_OCC_EN
    exp_lat = 5'd1;
`endif
    tick();
    n_cmp += 2;
    if (qvld !== 1'b0) begin n_bad++; $display("FAIL lat1_chg_qvld got %b want 0", qvld); end
    if (busy !== 1'b1) begin n_bad++; $display("FAIL lat1_chg_busy got %b want 1", busy); end
    for (int k = 0; k < 3; k++) begin
      din = d; dvld = 1'b1;
      tick();
      n_cmp += 3;
      if (qvld !== 1'b1) begin n_bad++; $display("FAIL lat1_qvld k=%0d got %b want 1", k, qvld); end
      if (qout !== d) begin n_bad++; $display("FAIL lat1_qout k=%0d got %h want %h", k, qout, d); end
      if (busy !== 1'b0) begin n_bad++; $display("FAIL lat1_busy k=%0d got %b want 0", k, busy); end
      d++;
    end
    lat = 5'd16; din = 8'h66; dvld = 1'b1;
`ifdef HD_LAT_OCC_EN
    exp_lat = 5'd16;
`endif
    tick();
    n_cmp++;
    if (qvld !== 1'b0) begin n_bad++; $display("FAIL lat16_chg_qvld got %b want 0", qvld); end
    for (int k = 1; k <= 17; k++) begin
      din = d; dvld = 1'b1;
      tick();
      n_cmp += 2;
      if (qvld !== (k >= 16)) begin n_bad++; $display("FAIL lat16_qvld k=%0d got %b want %b", k, qvld, (k >= 16)); end
      if (busy !== (k < 15)) begin n_bad++; $display("FAIL lat16_busy k=%0d got %b want %b", k, busy, (k < 15)); end
      if (k >= 16) begin
        n_cmp++;
        if (qout !== 8'(d - 8'd15)) begin n_bad++; $display("FAIL lat16_qout k=%0d got %h want %h", k, qout, 8'(d - 8'd15)); end
      end
      d++;
    end
    lat = 5'd4; din = 8'h77; dvld = 1'b1;
    tick();
`ifdef HD_LAT_OCC_EN
    exp_lat = 5'd4;
`endif
    for (int k = 1; k <= 4; k++) begin
      din = d; dvld = 1'b1;
      tick();
      d++;
    end
    n_cmp += 2;
    if (qvld !== 1'b1) begin n_bad++; $display("FAIL lat4_back_qvld got %b want 1", qvld); end
    if (qout !== 8'(d - 8'd4)) begin n_bad++; $display("FAIL lat4_back_qout got %h want %h", qout, 8'(d - 8'd4)); end
  endtask

  task automatic test_illegal();
    logic [LAT_W-1:0] bad_lat [2];
    bad_lat[0] = 5'd0;
    bad_lat[1] = 5'd17;
    for (int b = 0; b < 2; b++) begin
      lat = bad_lat[b];
      for (int k = 0; k < 2; k++) begin
        din = d; dvld = 1'b1;
        tick();
        n_cmp += 4;
        if (lat_err !== 1'b1) begin n_bad++; $display("FAIL ill_laterr lat=%0d got %b want 1", lat, lat_err); end
        if (qvld !== 1'b1) begin n_bad++; $display("FAIL ill_qvld lat=%0d got %b want 1", lat, qvld); end
        if (qout !== 8'(d - 8'd3)) begin n_bad++; $display("FAIL ill_qout lat=%0d got %h want %h", lat, qout, 8'(d - 8'd3)); end
        if (busy !== 1'b0) begin n_bad++; $display("FAIL ill_busy lat=%0d got %b want 0", lat, busy); end
        d++;
      end
    end
    lat = 5'd4; din = d; dvld = 1'b1;
    tick();
    n_cmp += 4;
    if (lat_err !== 1'b0) begin n_bad++; $display("FAIL legal_laterr got %b want 0", lat_err); end
    if (qvld !== 1'b1) begin n_bad++; $display("FAIL legal_qvld got %b want 1", qvld); end
    if (qout !== 8'(d - 8'd3)) begin n_bad++; $display("FAIL legal_qout got %h want %h", qout, 8'(d - 8'd3)); end
    if (busy !== 1'b0) begin n_bad++; $display("FAIL legal_busy got %b want 0", busy); end
    d++;
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < 2; k++) begin
      din = d; dvld = 1'b1;
      tick();
      d++;
    end
`ifdef HD_LAT_OCC_EN
    n_cmp++;
    if (occ !== 5'd4) begin n_bad++; $display("FAIL pre_rst_occ got %0d want 4", occ); end
`endif
    #2;
    rst = 1'b0;
    #1;
    n_cmp += 3;
    if (qout !== 8'h00) begin n_bad++; $display("FAIL arst_qout got %h want 00", qout); end
    if (qvld !== 1'b0)  begin n_bad++; $display("FAIL arst_qvld got %b want 0", qvld); end
    if (busy !== 1'b1)  begin n_bad++; $display("FAIL arst_busy got %b want 1", busy); end
`ifdef HD_LAT_OCC_EN
    n_cmp++;
    if (occ !== 5'd0) begin n_bad++; $display("FAIL arst_occ got %0d want 0", occ); end
`endif
    @(negedge clk);
    n_cmp++;
    if (qvld !== 1'b0) begin n_bad++; $display("FAIL arst_hold_qvld got %b want 0", qvld); end
    rst = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      din = d; dvld = 1'b1;
      tick();
      n_cmp += 2;
      if (busy !== (k < 3)) begin n_bad++; $display("FAIL rerun_busy k=%0d got %b want %b", k, busy, (k < 3)); end
      if (qvld !== (k >= 4)) begin n_bad++; $display("FAIL rerun_qvld k=%0d got %b want %b", k, qvld, (k >= 4)); end
      if (k >= 4) begin
        n_cmp++;
        if (qout !== 8'(d - 8'd3)) begin n_bad++; $display("FAIL rerun_qout k=%0d got %h want %h", k, qout, 8'(d - 8'd3)); end
      end
      d++;
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    d     = 8'h00;
`ifdef HD_LAT_OCC_EN
    exp_lat = 5'd4;
`endif
    test_reset();
    test_run();
    test_stall();
    test_flush();
    test_lat_change();
    test_illegal();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hd_latency_pipe.md
Name: hd_latency_pipe

Overview:
- Parametrised, runtime-programmable latency matcher for the Hamming encoder/decoder sim environment.
- Delays a data word and its valid flag by a selectable number of enabled clock cycles, so that reference data lines up with DUT output.
- Adds a stall enable, synchronous flush and a controlled latency-change sequence.
- Instantiated in the scoreboard path between stimulus generator and checker.

Parameters:
- W, 8, data width in bits.
- MAX_LAT, 16, maximum supported latency in enabled cycles (>=1).
- DEF_LAT, 4, latency loaded at reset (1..MAX_LAT).
- LAT_W, $clog2(MAX_LAT+1), width of the latency select and counters.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  advance; 0 = stall, all state held.
- flush  in  1  synchronous; discards all in-flight samples.
- lat  in  LAT_W  requested latency, 1..MAX_LAT.
- din  in  W  data in.
- dvld  in  1  data valid in.
- qout  out  W  delayed data.
- qvld  out  1  delayed valid.
- busy  out  1  pipe refilling after reset/flush/latency change.
- lat_err  out  1  registered; lat is 0 or >MAX_LAT.

Behaviour:
- Reset (rst=0, async): all MAX_LAT data stages = 0, valid stages = 0, qout = 0, qvld = 0, lat_q = DEF_LAT, fill counter = 0, state = FILL, busy = 1, lat_err = 0.
- Latency: with en=1 on every edge, din/dvld captured at edge N appear on qout/qvld after edge N+lat_q-1. lat_q=1 is a single register stage.
- Stall: with en=0, no stage moves, qout/qvld hold, fill counter holds. Stalled edges do not count toward latency.
- Storage: MAX_LAT-deep circular buffer or shift register. Only lat_q stages are effective; qout is taken from the stage lat_q-1 positions behind the write point.
- FSM states FILL, RUN:
  - FILL: busy=1. The fill counter increments on each en=1 edge. The state moves to RUN on the edge where the counter reaches lat_q-1. With lat_q=1, RUN follows one en edge.
  - RUN: busy=0.
  - Any flush or accepted latency change returns the FSM to FILL with counter = 0.
- Flush (flush=1 at an edge, regardless of en): all valid stages cleared, qvld=0 after that edge, data stages untouched. The din/dvld on that edge is discarded. The FSM goes to FILL.
- Latency change: evaluated every edge regardless of en.
  - If lat differs from lat_q and is legal: lat_q <= lat, all valid stages cleared (same effect as flush), FSM goes to FILL.
  - Flush and latency change on the same edge: both take effect, and lat_q takes the new value.
- Illegal lat (0 or >MAX_LAT): lat_err=1 on the next edge. lat_q is kept, no flush occurs, and data continues normally. lat_err clears on the first edge where lat is legal.
- qvld during FILL is always 0, because the valid stages were cleared. qout is undefined-but-deterministic (stale data stages) and must not be checked when qvld=0.
- Reset mid-operation: the async reset dominates everything, and all in-flight samples are lost.
- No arithmetic on data; counters saturate and never wrap.

Optional Feature:
- Macro HD_LAT_OCC_EN.
- Defined: adds output port occ (LAT_W bits), the count of valid samples currently in the effective lat_q stages.
  - Per en=1 edge: +1 if dvld enters, -1 if a valid leaves past qout. Simultaneous in and out leaves occ unchanged.
  - occ = 0 on reset, flush or latency change.
  - The bench asserts occ <= lat_q.
- Undefined: the port and its counter are absent. All other behaviour is identical.

Decomposition:
- Package hd_lat_pkg:
  - state enum {FILL, RUN}.
  - Legal-latency check function.
  - Default constants for W, MAX_LAT and DEF_LAT used by the sim env.
- Sub-module hd_lat_ctrl:
  - Contains the FSM, fill counter, lat_q register, lat_err, and flush/change-detect logic.
  - Outputs a clear-valid pulse plus lat_q to the datapath in hd_latency_pipe.

Test Plan:
- Reset then RUN: W=8, DEF_LAT=4, en=1, din increments from 0x01 each cycle, dvld=1. busy is high for 3 edges after reset release. qout=0x01 with qvld=1 first appears after edge 4 from capture, and the sequence is contiguous thereafter.
- Stall: with lat_q=4 and data streaming, hold en=0 for 3 cycles. qout/qvld are frozen for those cycles, and the resumed sequence has no skipped or duplicated values.
- Flush: assert flush for one cycle mid-stream. qvld=0 for the next 4 enabled edges, busy=1 for 3. The first post-flush qout equals the din captured on the edge after flush.
- Latency change: switch lat 4->1 mid-stream. The pipe flushes; with lat_q=1, qout equals the din of the previous edge. Then switch 1->16: qvld stays 0 for 16 edges.
- Illegal latency: drive lat=0, then lat=17 (MAX_LAT=16). lat_err=1 for each, lat_q stays 4, and the data stream is uninterrupted. On return to lat=4, lat_err=0 and no flush occurs.
- Async reset mid-stream plus HD_LAT_OCC_EN: with 4 samples in flight (occ=4), pulse rst low between edges. Outputs immediately go to 0, busy=1, occ=0, and lat_q returns to DEF_LAT.
